// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control FSM for the Simple RISC Machine. It fetches instructions through the
// PC, decodes the instruction register and sequences the datapath. LDR and STR
// use a req/ack memory handshake guarded by a timeout watchdog. It also handles
// HALT and traps illegal opcodes.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   ir[15:0]       current instruction-register contents
//   mem_ack        memory completes the current request (one-cycle pulse)
//   nsel[2:0]      register select, one-hot: 100 Rn, 010 Rd, 001 Rm
//   vsel[1:0]      writeback source: 00 C, 01 mdata, 10 sximm8
//   loada/b/c/s    datapath register enables
//   asel, bsel     ALU A-zero select, B-sximm5 select
//   write          register-file write enable
//   load_ir        instruction-register load
//   load_pc        PC increment
//   reset_pc       PC clear
//   addr_sel       memory address source: 1 PC, 0 data-address register
//   load_addr      data-address register load
//   mem_req        memory request
//   mem_we         memory write qualifier
//   halted, err    status flags
module multicycle_controller #(
    parameter int MAX_WAIT = 15,
    parameter bit EN_MEM   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        mem_ack,
    output logic [2:0]  nsel,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        write,
    output logic        load_ir,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        addr_sel,
    output logic        load_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic        halted,
    output logic        err
);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_UPDATE_PC, S_DECODE, S_GETA, S_GETB, S_EXEC,
        S_WRITE_REG, S_WRITE_IMM, S_MEM_EXEC, S_MEM_ADDR, S_MEM_RD,
        S_LDR_WB, S_STR_GETD, S_STR_PASS, S_MEM_WR, S_HALT, S_ERROR
    } state_t;

    // Instruction class captured at DECODE. Later states branch and
    // qualify outputs on this class, so every output stays a registered
    // decode that does not depend on ir after DECODE.
    typedef enum logic [2:0] {
        OP_ALU, OP_CMP, OP_MOV, OP_MVN, OP_LDR, OP_STR
    } op_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic [7:0] wait_q, wait_d;

    // Only the opcode/op fields steer control; the operand fields go to the datapath.
    logic unused_ir;
    assign unused_ir = ^ir[10:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
            op_q    <= OP_ALU;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic. The wait counter defaults to zero, so any state
    // change clears it. It only counts while a request is left unacknowledged.
    // An ack on the last allowed cycle is checked first, so the ack wins.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = 8'd0;
        case (state_q)
            S_RST:       state_d = S_IF1;
            S_IF1: begin
                if (mem_ack)                  state_d = S_UPDATE_PC;
                else if (wait_q == WAIT_LAST) state_d = S_ERROR;
                else                          wait_d  = wait_q + 8'd1;
            end
            S_UPDATE_PC: state_d = S_DECODE;
            S_DECODE: begin
                casez (ir[15:11])
                    5'b11010: state_d = S_WRITE_IMM;
                    5'b11000: begin op_d = OP_MOV; state_d = S_GETB; end
                    5'b10100: begin op_d = OP_ALU; state_d = S_GETA; end
                    5'b10101: begin op_d = OP_CMP; state_d = S_GETA; end
                    5'b10110: begin op_d = OP_ALU; state_d = S_GETA; end
                    5'b10111: begin op_d = OP_MVN; state_d = S_GETB; end
                    5'b01100: begin
                        op_d    = OP_LDR;
                        state_d = EN_MEM ? S_GETA : S_ERROR;
                    end
                    5'b10000: begin
                        op_d    = OP_STR;
                        state_d = EN_MEM ? S_GETA : S_ERROR;
                    end
                    5'b111??: state_d = S_HALT;
                    default:  state_d = S_ERROR;
                endcase
            end
            S_GETA:      state_d = (op_q == OP_LDR || op_q == OP_STR) ? S_MEM_EXEC : S_GETB;
            S_GETB:      state_d = S_EXEC;
            S_EXEC:      state_d = (op_q == OP_CMP) ? S_IF1 : S_WRITE_REG;
            S_WRITE_REG: state_d = S_IF1;
            S_WRITE_IMM: state_d = S_IF1;
            S_MEM_EXEC:  state_d = S_MEM_ADDR;
            S_MEM_ADDR:  state_d = (op_q == OP_LDR) ? S_MEM_RD : S_STR_GETD;
            S_MEM_RD: begin
                if (mem_ack)                  state_d = S_LDR_WB;
                else if (wait_q == WAIT_LAST) state_d = S_ERROR;
                else                          wait_d  = wait_q + 8'd1;
            end
            S_LDR_WB:    state_d = S_IF1;
            S_STR_GETD:  state_d = S_STR_PASS;
            S_STR_PASS:  state_d = S_MEM_WR;
            S_MEM_WR: begin
                if (mem_ack)                  state_d = S_IF1;
                else if (wait_q == WAIT_LAST) state_d = S_ERROR;
                else                          wait_d  = wait_q + 8'd1;
            end
            S_HALT:      state_d = S_HALT;
            S_ERROR:     state_d = S_ERROR;
            default:     state_d = S_ERROR;
        endcase
    end

    // Moore output decode
    always_comb begin
        nsel      = 3'b000;
        vsel      = 2'b00;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        write     = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        addr_sel  = 1'b0;
        load_addr = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        halted    = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_RST:       begin reset_pc = 1'b1; addr_sel = 1'b1; end
            // IR is loaded throughout IF1 and holds the word present on the ack cycle.
            S_IF1:       begin mem_req = 1'b1; addr_sel = 1'b1; load_ir = 1'b1; end
            S_UPDATE_PC: load_pc = 1'b1;
            S_GETA:      begin nsel = 3'b100; loada = 1'b1; end
            S_GETB:      begin nsel = 3'b001; loadb = 1'b1; end
            S_EXEC: begin
                loadc = 1'b1;
                asel  = (op_q == OP_MOV || op_q == OP_MVN);
                loads = (op_q == OP_CMP);
            end
            S_WRITE_REG: begin write = 1'b1; nsel = 3'b010; end
            S_WRITE_IMM: begin write = 1'b1; vsel = 2'b10; nsel = 3'b100; end
            S_MEM_EXEC:  begin bsel = 1'b1; loadc = 1'b1; end
            S_MEM_ADDR:  load_addr = 1'b1;
            S_MEM_RD:    mem_req = 1'b1;
            S_LDR_WB:    begin write = 1'b1; vsel = 2'b01; nsel = 3'b010; end
            S_STR_GETD:  begin nsel = 3'b010; loadb = 1'b1; end
            S_STR_PASS:  begin asel = 1'b1; loadc = 1'b1; end
            S_MEM_WR:    begin mem_req = 1'b1; mem_we = 1'b1; end
            S_HALT:      halted = 1'b1;
            S_ERROR:     err = 1'b1;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller (MAX_WAIT=4). Each stimulus cycle queues
// the hand-derived output vector expected for that cycle; a negedge monitor
// pops and compares against the full output bundle.
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [15:0] ir;
    logic        mem_ack;
    logic [2:0]  nsel;
    logic [1:0]  vsel;
    logic        loada, loadb, loadc, loads, asel, bsel, write;
    logic        load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic        mem_req, mem_we, halted, err;

    int errors = 0;
    int checks = 0;

    // Output bundle bit positions
    localparam logic [20:0] NS_RN     = 21'd4 << 18;
    localparam logic [20:0] NS_RD     = 21'd2 << 18;
    localparam logic [20:0] NS_RM     = 21'd1 << 18;
    localparam logic [20:0] VS_MD     = 21'd1 << 16;
    localparam logic [20:0] VS_IMM    = 21'd2 << 16;
    localparam logic [20:0] LOADA     = 21'd1 << 15;
    localparam logic [20:0] LOADB     = 21'd1 << 14;
    localparam logic [20:0] LOADC     = 21'd1 << 13;
    localparam logic [20:0] LOADS     = 21'd1 << 12;
    localparam logic [20:0] ASEL      = 21'd1 << 11;
    localparam logic [20:0] BSEL      = 21'd1 << 10;
    localparam logic [20:0] WRITE     = 21'd1 << 9;
    localparam logic [20:0] LOAD_IR   = 21'd1 << 8;
    localparam logic [20:0] LOAD_PC   = 21'd1 << 7;
    localparam logic [20:0] RESET_PC  = 21'd1 << 6;
    localparam logic [20:0] ADDR_SEL  = 21'd1 << 5;
    localparam logic [20:0] LOAD_ADDR = 21'd1 << 4;
    localparam logic [20:0] MEM_REQ   = 21'd1 << 3;
    localparam logic [20:0] MEM_WE    = 21'd1 << 2;
    localparam logic [20:0] HALTED    = 21'd1 << 1;
    localparam logic [20:0] ERR       = 21'd1;

    // Expected vectors per control step
    localparam logic [20:0] E_RST     = RESET_PC | ADDR_SEL;
    localparam logic [20:0] E_IF1     = MEM_REQ | ADDR_SEL | LOAD_IR;
    localparam logic [20:0] E_UPC     = LOAD_PC;
    localparam logic [20:0] E_DEC     = 21'd0;
    localparam logic [20:0] E_GETA    = NS_RN | LOADA;
    localparam logic [20:0] E_GETB    = NS_RM | LOADB;
    localparam logic [20:0] E_EXEC    = LOADC;
    localparam logic [20:0] E_EXEC_A  = LOADC | ASEL;
    localparam logic [20:0] E_EXEC_S  = LOADC | LOADS;
    localparam logic [20:0] E_WREG    = WRITE | NS_RD;
    localparam logic [20:0] E_WIMM    = WRITE | VS_IMM | NS_RN;
    localparam logic [20:0] E_MEXEC   = BSEL | LOADC;
    localparam logic [20:0] E_MADDR   = LOAD_ADDR;
    localparam logic [20:0] E_MRD     = MEM_REQ;
    localparam logic [20:0] E_LDRWB   = WRITE | VS_MD | NS_RD;
    localparam logic [20:0] E_SGETD   = NS_RD | LOADB;
    localparam logic [20:0] E_SPASS   = ASEL | LOADC;
    localparam logic [20:0] E_MWR     = MEM_REQ | MEM_WE;
    localparam logic [20:0] E_HALT    = HALTED;
    localparam logic [20:0] E_ERR     = ERR;

    typedef struct {
        logic [20:0] vec;
        string       tag;
    } exp_t;

    exp_t expq[$];

    logic [20:0] act;
    assign act = {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
                  load_ir, load_pc, reset_pc, addr_sel, load_addr,
                  mem_req, mem_we, halted, err};

    multicycle_controller #(.MAX_WAIT(4), .EN_MEM(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .ir        (ir),
        .mem_ack   (mem_ack),
        .nsel      (nsel),
        .vsel      (vsel),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .asel      (asel),
        .bsel      (bsel),
        .write     (write),
        .load_ir   (load_ir),
        .load_pc   (load_pc),
        .reset_pc  (reset_pc),
        .addr_sel  (addr_sel),
        .load_addr (load_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .halted    (halted),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [20:0] got, input logic [20:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %b required %b", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected for that cycle.
    task automatic applyStimulus(input logic rst_v, input logic [15:0] ir_v,
                                 input logic ack_v, input logic [20:0] exp_v,
                                 input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset   = rst_v;
        ir      = ir_v;
        mem_ack = ack_v;
        e.vec   = exp_v;
        e.tag   = tag;
        expq.push_back(e);
    endtask

    // IF1 with an immediate ack, then UPDATE_PC and DECODE
    task automatic fetch(input logic [15:0] ir_v, input string tag);
        applyStimulus(1'b1, ir_v, 1'b1, E_IF1, {tag, "_if1"});
        applyStimulus(1'b1, ir_v, 1'b0, E_UPC, {tag, "_upc"});
        applyStimulus(1'b1, ir_v, 1'b0, E_DEC, {tag, "_dec"});
    endtask

    task automatic resetPulse(input string tag);
        applyStimulus(1'b0, 16'h0000, 1'b0, E_RST, {tag, "_rst0"});
        applyStimulus(1'b0, 16'h0000, 1'b0, E_RST, {tag, "_rst1"});
        applyStimulus(1'b1, 16'h0000, 1'b0, E_RST, {tag, "_rel"});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            checkOutput(e.tag, act, e.vec);
        end
    end

    initial begin
        exp_t e;
        reset   = 1'b0;
        ir      = 16'h0000;
        mem_ack = 1'b0;

        resetPulse("init");

        // MOV R2,#5
        fetch(16'hD205, "movi");
        applyStimulus(1'b1, 16'hD205, 1'b0, E_WIMM, "movi_wimm");

        // ADD R5,R0,R1 with one wait cycle in IF1
        applyStimulus(1'b1, 16'hA0A1, 1'b0, E_IF1, "add_if1_wait");
        fetch(16'hA0A1, "add");
        applyStimulus(1'b1, 16'hA0A1, 1'b0, E_GETA, "add_geta");
        applyStimulus(1'b1, 16'hA0A1, 1'b0, E_GETB, "add_getb");
        applyStimulus(1'b1, 16'hA0A1, 1'b0, E_EXEC, "add_exec");
        applyStimulus(1'b1, 16'hA0A1, 1'b0, E_WREG, "add_wreg");

        // CMP: no writeback, straight back to IF1
        fetch(16'hA901, "cmp");
        applyStimulus(1'b1, 16'hA901, 1'b0, E_GETA, "cmp_geta");
        applyStimulus(1'b1, 16'hA901, 1'b0, E_GETB, "cmp_getb");
        applyStimulus(1'b1, 16'hA901, 1'b0, E_EXEC_S, "cmp_exec");

        // MOV R0,R1 (register form)
        fetch(16'hC001, "movr");
        applyStimulus(1'b1, 16'hC001, 1'b0, E_GETB, "movr_getb");
        applyStimulus(1'b1, 16'hC001, 1'b0, E_EXEC_A, "movr_exec");
        applyStimulus(1'b1, 16'hC001, 1'b0, E_WREG, "movr_wreg");

        // LDR with ack on the 4th MEM_RD cycle (counter boundary, ack wins)
        fetch(16'h6143, "ldr");
        applyStimulus(1'b1, 16'h6143, 1'b0, E_GETA, "ldr_geta");
        applyStimulus(1'b1, 16'h6143, 1'b0, E_MEXEC, "ldr_mexec");
        applyStimulus(1'b1, 16'h6143, 1'b0, E_MADDR, "ldr_maddr");
        applyStimulus(1'b1, 16'h6143, 1'b0, E_MRD, "ldr_mrd1");
        applyStimulus(1'b1, 16'h6143, 1'b0, E_MRD, "ldr_mrd2");
        applyStimulus(1'b1, 16'h6143, 1'b0, E_MRD, "ldr_mrd3");
        applyStimulus(1'b1, 16'h6143, 1'b1, E_MRD, "ldr_mrd4");
        applyStimulus(1'b1, 16'h6143, 1'b0, E_LDRWB, "ldr_wb");

        // STR with ack on the 2nd MEM_WR cycle
        fetch(16'h8143, "str");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_GETA, "str_geta");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_MEXEC, "str_mexec");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_MADDR, "str_maddr");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_SGETD, "str_getd");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_SPASS, "str_pass");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_MWR, "str_mwr1");
        applyStimulus(1'b1, 16'h8143, 1'b1, E_MWR, "str_mwr2");

        // STR without ack: four unacknowledged cycles then ERROR
        fetch(16'h8143, "sto");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_GETA, "sto_geta");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_MEXEC, "sto_mexec");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_MADDR, "sto_maddr");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_SGETD, "sto_getd");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_SPASS, "sto_pass");
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b1, 16'h8143, 1'b0, E_MWR, $sformatf("sto_mwr%0d", i));
        applyStimulus(1'b1, 16'h8143, 1'b1, E_ERR, "sto_err0");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_ERR, "sto_err1");
        resetPulse("sto");

        // STR with ack on the 4th MEM_WR cycle: no error
        fetch(16'h8143, "stb");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_GETA, "stb_geta");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_MEXEC, "stb_mexec");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_MADDR, "stb_maddr");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_SGETD, "stb_getd");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_SPASS, "stb_pass");
        for (int i = 1; i <= 3; i++)
            applyStimulus(1'b1, 16'h8143, 1'b0, E_MWR, $sformatf("stb_mwr%0d", i));
        applyStimulus(1'b1, 16'h8143, 1'b1, E_MWR, "stb_mwr4");
        applyStimulus(1'b1, 16'h8143, 1'b0, E_IF1, "stb_if1");

        // HALT stays put under random mem_ack
        applyStimulus(1'b1, 16'hE000, 1'b1, E_IF1, "halt_if1");
        applyStimulus(1'b1, 16'hE000, 1'b0, E_UPC, "halt_upc");
        applyStimulus(1'b1, 16'hE000, 1'b0, E_DEC, "halt_dec");
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b1, 16'hE000, 1'($urandom_range(0, 1)), E_HALT,
                          $sformatf("halt_%0d", i));
        resetPulse("halt");

        // Illegal opcode traps
        fetch(16'h0000, "ill");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 16'h0000, 1'b1, E_ERR, $sformatf("ill_err%0d", i));
        resetPulse("ill");

        // Asynchronous reset in the middle of MEM_RD
        fetch(16'h6143, "ar");
        applyStimulus(1'b1, 16'h6143, 1'b0, E_GETA, "ar_geta");
        applyStimulus(1'b1, 16'h6143, 1'b0, E_MEXEC, "ar_mexec");
        applyStimulus(1'b1, 16'h6143, 1'b0, E_MADDR, "ar_maddr");
        applyStimulus(1'b1, 16'h6143, 1'b0, E_MRD, "ar_mrd1");
        @(posedge clk);
        #2;
        reset = 1'b0;
        e.vec = E_RST;
        e.tag = "ar_async";
        expq.push_back(e);
        applyStimulus(1'b0, 16'h6143, 1'b1, E_RST, "ar_hold");
        applyStimulus(1'b1, 16'h6143, 1'b0, E_RST, "ar_rel");
        applyStimulus(1'b1, 16'h6143, 1'b0, E_IF1, "ar_if1");

        repeat (2) @(posedge clk);
        #1;
        checkOutput("queue_drained", 21'(expq.size()), 21'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised next-generation control FSM for the Simple RISC Machine.
- Adds autonomous instruction fetch through a program counter, plus LDR/STR with a req/ack memory handshake, a memory-timeout watchdog, HALT, and illegal-opcode trapping.
- Drives the existing datapath controls (nsel, vsel, loada/b/c, loads, asel, bsel, write).
- Sits between the instruction register, datapath, PC/address registers and the memory port.

Parameters:
- MAX_WAIT, 15, cycles mem_req may stay unacknowledged before trapping to ERROR (1..255).
- EN_MEM, 1, when 0, LDR/STR opcodes are treated as illegal.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- ir  input  16  current instruction-register contents
- mem_ack  input  1  memory completes the current request (single-cycle pulse)
- nsel  output  3  one-hot register select: 100 Rn, 010 Rd, 001 Rm, 000 none
- vsel  output  2  writeback source: 00 datapath C, 01 mdata, 10 sximm8
- loada, loadb, loadc, loads  output  1 each  datapath register enables
- asel, bsel  output  1 each  ALU A-zero select, B-sximm5 select
- write  output  1  register-file write enable
- load_ir  output  1  instruction-register load
- load_pc, reset_pc  output  1 each  PC increment / PC clear
- addr_sel  output  1  1: memory address from PC; 0: from data-address register
- load_addr  output  1  data-address register load (from C)
- mem_req, mem_we  output  1 each  memory request / write qualifier
- halted, err  output  1 each  status flags

Behaviour:
- Moore machine with a registered state; all outputs decode from the state only.
- Reset asserted (reset=0), at any time including mid-transaction:
  - state goes to RST immediately.
  - All outputs are 0 except reset_pc=1 and addr_sel=1.
  - Timeout counter clears.
- State flow:
  - RST -> IF1 on the first clock after reset deasserts.
  - IF1: mem_req=1, addr_sel=1. Stays in IF1 until mem_ack, with load_ir=1 in the same cycle. On ack -> UPDATE_PC.
  - UPDATE_PC: load_pc=1 -> DECODE.
- DECODE branches on {ir[15:13], ir[12:11]}:
  - 11010 -> WRITE_IMM
  - 11000 MOV reg -> GETB
  - 10100/10101/10110 ADD/CMP/AND -> GETA
  - 10111 MVN -> GETB
  - 01100 LDR, 10000 STR -> GETA (only if EN_MEM=1)
  - 111xx -> HALT
  - anything else -> ERROR
- GETA: nsel=100, loada=1. Next state is GETB for ALU ops, MEM_EXEC for LDR/STR.
- GETB: nsel=001, loadb=1 -> EXEC.
- EXEC: loadc=1.
  - asel=1 for MOV reg and MVN; loads=1 only for CMP.
  - CMP -> IF1 (no writeback); all others -> WRITE_REG.
- WRITE_REG: write=1, vsel=00, nsel=010 -> IF1.
- WRITE_IMM: write=1, vsel=10, nsel=100 -> IF1.
- MEM_EXEC: asel=0, bsel=1, loadc=1 (Rn + sximm5) -> MEM_ADDR.
- MEM_ADDR: load_addr=1. LDR -> MEM_RD; STR -> STR_GETD.
- MEM_RD: mem_req=1, addr_sel=0. On mem_ack -> LDR_WB.
- LDR_WB: write=1, vsel=01, nsel=010 -> IF1.
- STR_GETD: nsel=010, loadb=1 -> STR_PASS.
- STR_PASS: asel=1, bsel=0, loadc=1 -> MEM_WR.
- MEM_WR: mem_req=1, mem_we=1, addr_sel=0. On mem_ack -> IF1.
- Timeout watchdog:
  - Counter increments each cycle mem_req=1 and mem_ack=0; it clears on ack and on any state change.
  - When the counter reaches MAX_WAIT with no ack -> ERROR.
  - An ack arriving on the same cycle as the counter reaching MAX_WAIT wins: the request completes normally.
- HALT: halted=1. ERROR: err=1. Both are absorbing states; only reset exits them. mem_ack is ignored there.
- mem_ack outside a mem_req state is ignored.
- ALU instruction latency with 0-wait memory: ADD = 7 cycles IF1 -> WRITE_REG inclusive. The next IF1 follows WRITE_REG.

Test Plan:
- Reset pulse, then ir=16'hD205 (MOV R2,#5) with mem_ack high in IF1 -> sequence IF1, UPDATE_PC, DECODE, WRITE_IMM: write=1, vsel=10, nsel=100 in cycle 4; load_pc pulses exactly once.
- ir=16'hA0A1 (ADD R5,R0,R1), ack immediate -> loada in cycle 4, loadb in cycle 5, loadc in cycle 6 (asel=0, loads=0), write with nsel=010 in cycle 7.
- ir=16'hA901 (CMP) -> loads=1 in EXEC, write never asserted; returns to IF1.
- LDR ir=16'h6143, with mem_ack delayed 3 cycles in MEM_RD -> mem_req/addr_sel=0 held 4 cycles, then write=1, vsel=01; STR variant -> mem_we=1 held until ack.
- MAX_WAIT=4, no ack in MEM_WR -> err=1 after 4 unacknowledged cycles; repeat with ack on cycle 4 -> err stays 0.
- ir=16'hE000 -> halted=1 held for 20 cycles under random mem_ack; ir=16'h0000 -> err=1; reset=0 asserted asynchronously mid-MEM_RD -> outputs clear without waiting for a clock edge.
